arb_resp_router: RTL and testbench
==================================

// Module: arb_resp_router
// PURPOSE
//  Return path for the request arbiter. Records the arbiter's chosen input index on every
//  granted request, in a tag FIFO. Steers each in-order downstream response back to the
//  requester that issued it. Sits between the shared downstream port and NUM_PORTS requesters.
// PARAMETERS
//  NUM_PORTS  2   number of requesters / arbiter inputs (>=2)
//  DEPTH      4   max outstanding requests; tag FIFO entries (power of 2, >=2)
//  DATA_W     32  response payload width
//  (CW = $clog2(NUM_PORTS), PW = $clog2(DEPTH), OW = $clog2(DEPTH+1))
// PORTS
//  clock              in   1          rising-edge clock
//  reset_n            in   1          asynchronous, active-low reset
//  io_req_fire        in   1          arbiter output valid&ready this cycle
//  io_req_chosen      in   CW         arbiter chosen index, sampled when io_req_fire=1
//  io_req_stall       out  1          tag FIFO full; arbiter output ready must be gated low
//  io_resp_in_valid   in   1          downstream response valid
//  io_resp_in_ready   out  1          router accepts downstream response
//  io_resp_in_bits    in   DATA_W     downstream response payload
//  io_resp_out_valid  out  NUM_PORTS  per-requester response valid (one-hot or zero)
//  io_resp_out_ready  in   NUM_PORTS  per-requester response ready
//  io_resp_out_bits   out  DATA_W     response payload, shared by all requesters
//  io_outstanding     out  OW         number of tags currently held
//  io_err_overflow    out  1          sticky: io_req_fire arrived while push impossible
//  io_err_orphan      out  1          sticky: io_resp_in_valid arrived with FIFO empty
// BEHAVIOUR
//  Reset (reset_n=0, async):
//   - wr_ptr=rd_ptr=0, count=0, both error flags cleared.
//   - io_req_stall=0, io_resp_in_ready=0, io_resp_out_valid=0, io_outstanding=0.
//   - FIFO contents are don't-care.
//  Reset asserted mid-operation discards all outstanding tags. Responses still in flight
//  downstream after reset are then orphans.
//  Tag FIFO:
//   - push = io_req_fire && (count<DEPTH || pop).
//   - Push writes io_req_chosen at wr_ptr; wr_ptr += 1, wrapping mod DEPTH.
//   - io_req_fire && !push sets io_err_overflow. The tag is dropped and count is unchanged.
//   - io_req_stall = (count==DEPTH). It is registered state and is not relieved by a
//     same-cycle pop.
//  Response path (combinational, zero latency, no internal data storage):
//   - head = fifo[rd_ptr]; sel = (count!=0).
//   - io_resp_out_valid[i] = io_resp_in_valid && sel && (head==i); all other bits are 0.
//   - io_resp_out_bits = io_resp_in_bits, driven unconditionally.
//   - io_resp_in_ready = sel && io_resp_out_ready[head].
//   - pop = io_resp_in_valid && io_resp_in_ready; rd_ptr += 1, wrapping mod DEPTH.
//   - io_resp_out_valid must not depend on io_resp_out_ready (no valid-on-ready loop).
//  Count:
//   - count_next = count + push - pop; io_outstanding = count.
//   - Push and pop in the same cycle leave count unchanged, including when count==DEPTH.
//  No bypass: a tag pushed in cycle t can route a response from cycle t+1 onward. With
//  count==0 a response is never routed in the same cycle as the push, even if simultaneous.
//  Empty: io_resp_in_valid with count==0 holds io_resp_in_ready=0 and sets io_err_orphan.
//  Error flags are cleared only by reset.
//  Head index >= NUM_PORTS (non-power-of-2 NUM_PORTS): response is stalled; no out-valid.
//  Ordering: responses are routed strictly in request-grant order (in-order downstream).
// TESTING
//  1. Reset: reset_n=0 mid-traffic with 3 tags held -> all outputs 0 immediately;
//     after release io_outstanding=0 and a response raises io_err_orphan=1.
//  2. Order: grants chosen=1,0,1, then 3 responses 0xA,0xB,0xC with all ready=1
//     -> out_valid=2'b10,2'b01,2'b10 with bits 0xA,0xB,0xC; io_outstanding 3->0.
//  3. Backpressure: head tag=0, io_resp_out_ready=2'b10 -> io_resp_in_ready=0 and the
//     valid is held; ready[0]=1 next cycle -> pop and io_outstanding decrements.
//  4. Full/wrap: DEPTH=4, 4 grants -> io_req_stall=1. A 5th fire with no pop
//     -> io_err_overflow=1 and count stays 4. Pop+fire in the same cycle -> count stays 4.
//     Run 10 grant/response pairs -> pointers wrap and routing stays correct.
//  5. Empty push: response valid in the same cycle as the first grant -> not accepted,
//     io_err_orphan=1; accepted and routed on the next cycle.

Source files
------------

// File: rtl/arb_resp_router.sv
// arb_resp_router: return path for the request arbiter.
// Each granted request pushes the arbiter's chosen index into a tag FIFO.
// In-order downstream responses are then steered back to the requester at the FIFO head.
// The response path is purely combinational and holds no payload storage.
module arb_resp_router #(
  parameter int NUM_PORTS = 2,
  parameter int DEPTH     = 4,
  parameter int DATA_W    = 32,
  localparam int CW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 io_req_fire,
  input  logic [CW-1:0]        io_req_chosen,
  output logic                 io_req_stall,
  input  logic                 io_resp_in_valid,
  output logic                 io_resp_in_ready,
  input  logic [DATA_W-1:0]    io_resp_in_bits,
  output logic [NUM_PORTS-1:0] io_resp_out_valid,
  input  logic [NUM_PORTS-1:0] io_resp_out_ready,
  output logic [DATA_W-1:0]    io_resp_out_bits,
  output logic [OW-1:0]        io_outstanding,
  output logic                 io_err_overflow,
  output logic                 io_err_orphan
);

  logic [CW-1:0]        fifo_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]        count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 orph_q, orph_d;

  logic [CW-1:0]        head;
  logic                 sel;
  logic [NUM_PORTS-1:0] match;
  logic                 push;
  logic                 pop;

  // Decode the head tag against each requester; an out-of-range tag matches nothing and stalls.
  always_comb begin
    head = fifo_q[rd_ptr_q];
    sel  = (count_q != '0);
    match = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      match[i] = (head == CW'(i));
    end
  end

  // Response steering: valid depends only on downstream valid and the head tag, never on ready.
  always_comb begin
    io_resp_out_valid = (io_resp_in_valid && sel) ? match : '0;
    io_resp_out_bits  = io_resp_in_bits;
    io_resp_in_ready  = sel && |(match & io_resp_out_ready);
  end

  // Push/pop decisions and next-state for pointers, count and sticky error flags.
  always_comb begin
    pop      = io_resp_in_valid && io_resp_in_ready;
    push     = io_req_fire && ((count_q < OW'(DEPTH)) || pop);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + OW'(1);
      2'b01:   count_d = count_q - OW'(1);
      default: count_d = count_q;
    endcase
    ovf_d  = ovf_q  || (io_req_fire && !push);
    orph_d = orph_q || (io_resp_in_valid && !sel);
  end

  // Stall reflects the registered count, so a same-cycle pop does not release it.
  always_comb begin
    io_req_stall    = (count_q == OW'(DEPTH));
    io_outstanding  = count_q;
    io_err_overflow = ovf_q;
    io_err_orphan   = orph_q;
  end

  // Control state: pointers, occupancy and error flags, cleared by async reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      orph_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      orph_q   <= orph_d;
    end
  end

  // Tag storage: contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= io_req_chosen;
    end
  end

endmodule

// File: tb/tb_arb_resp_router.sv
// Directed bench for arb_resp_router (NUM_PORTS=2, DEPTH=4, DATA_W=32).
module tb_arb_resp_router;

  localparam int NUM_PORTS = 2;
  localparam int DEPTH     = 4;
  localparam int DATA_W    = 32;

  logic              clock;
  logic              reset_n;
  logic              io_req_fire;
  logic [0:0]        io_req_chosen;
  logic              io_req_stall;
  logic              io_resp_in_valid;
  logic              io_resp_in_ready;
  logic [DATA_W-1:0] io_resp_in_bits;
  logic [1:0]        io_resp_out_valid;
  logic [1:0]        io_resp_out_ready;
  logic [DATA_W-1:0] io_resp_out_bits;
  logic [2:0]        io_outstanding;
  logic              io_err_overflow;
  logic              io_err_orphan;

  int total = 0;
  int bad   = 0;

  arb_resp_router #(
    .NUM_PORTS (NUM_PORTS),
    .DEPTH     (DEPTH),
    .DATA_W    (DATA_W)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .io_req_fire       (io_req_fire),
    .io_req_chosen     (io_req_chosen),
    .io_req_stall      (io_req_stall),
    .io_resp_in_valid  (io_resp_in_valid),
    .io_resp_in_ready  (io_resp_in_ready),
    .io_resp_in_bits   (io_resp_in_bits),
    .io_resp_out_valid (io_resp_out_valid),
    .io_resp_out_ready (io_resp_out_ready),
    .io_resp_out_bits  (io_resp_out_bits),
    .io_outstanding    (io_outstanding),
    .io_err_overflow   (io_err_overflow),
    .io_err_orphan     (io_err_orphan)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks happen 2ns after.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic grant(input logic ch);
    io_req_fire   = 1'b1;
    io_req_chosen = ch;
    step();
    io_req_fire   = 1'b0;
  endtask

  initial begin
    logic [1:0] ev;
    reset_n           = 1'b0;
    io_req_fire       = 1'b0;
    io_req_chosen     = 1'b0;
    io_resp_in_valid  = 1'b0;
    io_resp_in_bits   = '0;
    io_resp_out_ready = 2'b00;

    // Reset state
    #2;
    chk("rst_stall",  64'(io_req_stall), 0);
    chk("rst_inrdy",  64'(io_resp_in_ready), 0);
    chk("rst_outvld", 64'(io_resp_out_valid), 0);
    chk("rst_outst",  64'(io_outstanding), 0);
    chk("rst_ovf",    64'(io_err_overflow), 0);
    chk("rst_orph",   64'(io_err_orphan), 0);
    step();
    reset_n = 1'b1;
    step();

    // Order: grants 1,0,1 then responses A,B,C
    grant(1'b1);
    grant(1'b0);
    grant(1'b1);
    settle();
    chk("ord_outst3", 64'(io_outstanding), 3);
    io_resp_out_ready = 2'b11;
    io_resp_in_valid  = 1'b1;
    io_resp_in_bits   = 32'hA;
    settle();
    chk("ord_v0", 64'(io_resp_out_valid), 2'b10);
    chk("ord_b0", 64'(io_resp_out_bits), 32'hA);
    chk("ord_r0", 64'(io_resp_in_ready), 1);
    step();
    io_resp_in_bits = 32'hB;
    settle();
    chk("ord_outst2", 64'(io_outstanding), 2);
    chk("ord_v1", 64'(io_resp_out_valid), 2'b01);
    chk("ord_b1", 64'(io_resp_out_bits), 32'hB);
    step();
    io_resp_in_bits = 32'hC;
    settle();
    chk("ord_v2", 64'(io_resp_out_valid), 2'b10);
    chk("ord_b2", 64'(io_resp_out_bits), 32'hC);
    step();
    io_resp_in_valid = 1'b0;
    settle();
    chk("ord_outst0", 64'(io_outstanding), 0);
    chk("ord_orph", 64'(io_err_orphan), 0);

    // Backpressure: head tag 0 with only requester 1 ready
    grant(1'b0);
    io_resp_in_valid  = 1'b1;
    io_resp_in_bits   = 32'h55;
    io_resp_out_ready = 2'b10;
    settle();
    chk("bp_rdy0", 64'(io_resp_in_ready), 0);
    chk("bp_vld0", 64'(io_resp_out_valid), 2'b01);
    step();
    settle();
    chk("bp_hold_outst", 64'(io_outstanding), 1);
    chk("bp_hold_vld", 64'(io_resp_out_valid), 2'b01);
    io_resp_out_ready = 2'b01;
    settle();
    chk("bp_rdy1", 64'(io_resp_in_ready), 1);
    step();
    io_resp_in_valid = 1'b0;
    io_resp_out_ready = 2'b11;
    settle();
    chk("bp_outst0", 64'(io_outstanding), 0);

    // Full: four grants 0,1,0,1
    for (int i = 0; i < 4; i++) grant(1'(i % 2));
    settle();
    chk("full_stall", 64'(io_req_stall), 1);
    chk("full_outst", 64'(io_outstanding), 4);
    chk("full_noovf", 64'(io_err_overflow), 0);
    grant(1'b1);
    settle();
    chk("ovf_flag", 64'(io_err_overflow), 1);
    chk("ovf_outst", 64'(io_outstanding), 4);
    // Pop and fire together while full; the stall stays up this cycle
    io_resp_in_valid = 1'b1;
    io_resp_in_bits  = 32'h100;
    io_req_fire      = 1'b1;
    io_req_chosen    = 1'b0;
    settle();
    chk("pf_stall", 64'(io_req_stall), 1);
    chk("pf_vld", 64'(io_resp_out_valid), 2'b01);
    chk("pf_rdy", 64'(io_resp_in_ready), 1);
    step();
    io_req_fire = 1'b0;
    io_resp_in_valid = 1'b0;
    settle();
    chk("pf_outst", 64'(io_outstanding), 4);
    // FIFO now holds 1,0,1,0 (the overflowed tag was dropped)
    io_resp_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      io_resp_in_bits = 32'(32'h200 + i);
      settle();
      ev = (i % 2 == 0) ? 2'b10 : 2'b01;
      chk("drain_vld", 64'(io_resp_out_valid), 64'(ev));
      chk("drain_bits", 64'(io_resp_out_bits), 64'(32'h200 + i));
      step();
    end
    io_resp_in_valid = 1'b0;
    settle();
    chk("drain_outst", 64'(io_outstanding), 0);
    chk("drain_stall", 64'(io_req_stall), 0);

    // Wrap: ten grant/response pairs
    for (int k = 0; k < 10; k++) begin
      grant(1'((k * 3 + 1) % 2));
      io_resp_in_valid = 1'b1;
      io_resp_in_bits  = 32'(32'h300 + k);
      settle();
      ev = (((k * 3 + 1) % 2) == 1) ? 2'b10 : 2'b01;
      chk("wrap_vld", 64'(io_resp_out_valid), 64'(ev));
      chk("wrap_bits", 64'(io_resp_out_bits), 64'(32'h300 + k));
      step();
      io_resp_in_valid = 1'b0;
    end
    settle();
    chk("wrap_outst", 64'(io_outstanding), 0);
    chk("wrap_orph", 64'(io_err_orphan), 0);

    // Empty push: response arrives with the first grant
    io_req_fire      = 1'b1;
    io_req_chosen    = 1'b1;
    io_resp_in_valid = 1'b1;
    io_resp_in_bits  = 32'h77;
    settle();
    chk("ep_rdy0", 64'(io_resp_in_ready), 0);
    chk("ep_vld0", 64'(io_resp_out_valid), 0);
    step();
    io_req_fire = 1'b0;
    settle();
    chk("ep_orph", 64'(io_err_orphan), 1);
    chk("ep_outst", 64'(io_outstanding), 1);
    chk("ep_rdy1", 64'(io_resp_in_ready), 1);
    chk("ep_vld1", 64'(io_resp_out_valid), 2'b10);
    step();
    io_resp_in_valid = 1'b0;
    settle();
    chk("ep_outst0", 64'(io_outstanding), 0);

    // Reset mid-traffic with three tags held
    grant(1'b0);
    grant(1'b1);
    grant(1'b0);
    io_resp_in_valid = 1'b1;
    settle();
    chk("mr_outst3", 64'(io_outstanding), 3);
    reset_n = 1'b0;
    #1;
    chk("mr_outst", 64'(io_outstanding), 0);
    chk("mr_vld", 64'(io_resp_out_valid), 0);
    chk("mr_rdy", 64'(io_resp_in_ready), 0);
    chk("mr_ovf", 64'(io_err_overflow), 0);
    chk("mr_orph", 64'(io_err_orphan), 0);
    io_resp_in_valid = 1'b0;
    step();
    reset_n = 1'b1;
    settle();
    chk("mr_rel_outst", 64'(io_outstanding), 0);
    io_resp_in_valid = 1'b1;
    settle();
    chk("mr_rel_rdy", 64'(io_resp_in_ready), 0);
    step();
    io_resp_in_valid = 1'b0;
    settle();
    chk("mr_orph_set", 64'(io_err_orphan), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
